// File: rtl/branch_resolve_unit.sv
// Registered branch-resolution stage: evaluates the MIPS conditional-branch set,
// computes the target, checks the front-end prediction and keeps saturating statistics.
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  InValid,
    input  logic                  CompareFlag,
    input  logic [2:0]            Control,
    input  logic [DATA_WIDTH-1:0] InA,
    input  logic [DATA_WIDTH-1:0] InB,
    input  logic [ADDR_WIDTH-1:0] PcPlus4,
    input  logic [ADDR_WIDTH-1:0] Offset,
    input  logic                  PredTaken,
    input  logic                  Stall,
    input  logic                  Flush,
    output logic                  OutValid,
    output logic                  Result,
    output logic [ADDR_WIDTH-1:0] Target,
    output logic                  Mispredict,
    output logic                  IllegalOp,
    output logic [CNT_WIDTH-1:0]  BranchCount,
    output logic [CNT_WIDTH-1:0]  TakenCount
);

    logic                  cap;
    logic                  valid_next;
    logic                  illegal_next;
    logic                  cond;
    logic                  result_next;
    logic                  pred_q;
    logic                  a_neg;
    logic                  a_zero;
    logic [ADDR_WIDTH-1:0] target_next;

    assign cap          = InValid & CompareFlag & (Control != 3'd0);
    assign valid_next   = cap & (Control != 3'd7);
    assign illegal_next = cap & (Control == 3'd7);
    assign a_neg        = InA[DATA_WIDTH-1];
    assign a_zero       = (InA == '0);
    assign target_next  = PcPlus4 + {Offset[ADDR_WIDTH-3:0], 2'b00};

    always_comb begin
        cond = 1'b0;
        case (Control)
            3'd1:    cond = (InA == InB);
            3'd2:    cond = a_neg | a_zero;
            3'd3:    cond = ~a_neg & ~a_zero;
            3'd4:    cond = a_neg;
            3'd5:    cond = ~a_neg;
            3'd6:    cond = (InA != InB);
            default: cond = 1'b0;
        endcase
    end

    // Taken is only reported for a resolved branch; otherwise Result stays low.
    assign result_next = valid_next & cond;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            OutValid    <= 1'b0;
            Result      <= 1'b0;
            Target      <= '0;
            IllegalOp   <= 1'b0;
            pred_q      <= 1'b0;
            BranchCount <= '0;
            TakenCount  <= '0;
        end else if (Flush) begin
            OutValid    <= 1'b0;
            Result      <= 1'b0;
            IllegalOp   <= 1'b0;
        end else if (!Stall) begin
            OutValid    <= valid_next;
            Result      <= result_next;
            Target      <= target_next;
            IllegalOp   <= illegal_next;
            pred_q      <= PredTaken;
            if (valid_next && (BranchCount != '1))
                BranchCount <= BranchCount + 1'b1;
            if (result_next && (TakenCount != '1))
                TakenCount <= TakenCount + 1'b1;
        end
    end

    // Derived from registered state only, so it holds under stall and clears with OutValid.
    assign Mispredict = OutValid & (Result != pred_q);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (CNT_WIDTH=4 to exercise saturation).
module tb_branch_resolve_unit;

    logic        Clk = 1'b0;
    logic        Reset, InValid, CompareFlag, PredTaken, Stall, Flush;
    logic [2:0]  Control;
    logic [31:0] InA, InB, PcPlus4, Offset;
    logic        OutValid, Result, Mispredict, IllegalOp;
    logic [31:0] Target;
    logic [3:0]  BranchCount, TakenCount;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned exp_bc = 0;
    int unsigned exp_tc = 0;

    branch_resolve_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .CNT_WIDTH (4)
    ) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .CompareFlag(CompareFlag),
        .Control(Control), .InA(InA), .InB(InB), .PcPlus4(PcPlus4), .Offset(Offset),
        .PredTaken(PredTaken), .Stall(Stall), .Flush(Flush), .OutValid(OutValid),
        .Result(Result), .Target(Target), .Mispredict(Mispredict), .IllegalOp(IllegalOp),
        .BranchCount(BranchCount), .TakenCount(TakenCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".bc"}, 32'(BranchCount), 32'(exp_bc));
        check({tag, ".tc"}, 32'(TakenCount), 32'(exp_tc));
    endtask

    task automatic branch(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          input logic pred);
        InValid = 1'b1; CompareFlag = 1'b1; Control = ctl; InA = a; InB = b; PredTaken = pred;
    endtask

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] a;
        logic        res;
    } zvec_t;

    zvec_t zv[6];

    initial begin
        zv[0] = '{3'd2, 32'hFFFFFFFF, 1'b1};
        zv[1] = '{3'd3, 32'hFFFFFFFF, 1'b0};
        zv[2] = '{3'd4, 32'hFFFFFFFF, 1'b1};
        zv[3] = '{3'd5, 32'hFFFFFFFF, 1'b0};
        zv[4] = '{3'd5, 32'h00000000, 1'b1};
        zv[5] = '{3'd3, 32'h00000000, 1'b0};

        Reset = 1'b1; InValid = 1'b0; CompareFlag = 1'b0; Control = 3'd0;
        InA = '0; InB = '0; PcPlus4 = '0; Offset = '0; PredTaken = 1'b0;
        Stall = 1'b0; Flush = 1'b0;
        tick(); tick();
        check("rst.ov",   32'(OutValid),   32'd0);
        check("rst.res",  32'(Result),     32'd0);
        check("rst.tgt",  Target,          32'd0);
        check("rst.misp", 32'(Mispredict), 32'd0);
        check("rst.ill",  32'(IllegalOp),  32'd0);
        check_counts("rst");

        // BEQ taken, predicted not taken
        Reset = 1'b0;
        branch(3'd1, 32'h5, 32'h5, 1'b0);
        PcPlus4 = 32'h100; Offset = 32'h4;
        tick();
        exp_bc = 1; exp_tc = 1;
        check("beq.ov",   32'(OutValid),   32'd1);
        check("beq.res",  32'(Result),     32'd1);
        check("beq.tgt",  Target,          32'h110);
        check("beq.misp", 32'(Mispredict), 32'd1);
        check_counts("beq");

        // Signed zero compares; InB is nonzero garbage and must be ignored
        for (int i = 0; i < 6; i++) begin
            branch(zv[i].ctl, zv[i].a, 32'h1234, 1'b1);
            tick();
            exp_bc++;
            if (zv[i].res) exp_tc++;
            check($sformatf("zc%0d.res", i),  32'(Result),     32'(zv[i].res));
            check($sformatf("zc%0d.misp", i), 32'(Mispredict), 32'(!zv[i].res));
        end
        check_counts("zc");

        // BNE not taken, then stall with changing inputs
        branch(3'd6, 32'h3, 32'h3, 1'b0);
        tick();
        exp_bc++;
        check("bne.ov",   32'(OutValid),   32'd1);
        check("bne.res",  32'(Result),     32'd0);
        check("bne.misp", 32'(Mispredict), 32'd0);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            branch(3'd1, 32'(i), 32'(i), 1'b1);
            PcPlus4 = 32'h200; Offset = 32'(i + 1);
            tick();
            check("stall.ov",   32'(OutValid),   32'd1);
            check("stall.res",  32'(Result),     32'd0);
            check("stall.misp", 32'(Mispredict), 32'd0);
            check("stall.tgt",  Target,          32'h110);
            check_counts("stall");
        end
        Flush = 1'b1;
        tick();
        check("flush.ov",  32'(OutValid), 32'd0);
        check("flush.res", 32'(Result),   32'd0);
        check("flush.tgt", Target,        32'h110);
        check_counts("flush");
        Stall = 1'b0; Flush = 1'b0;

        // Reserved code and non-branch instruction
        branch(3'd7, 32'h1, 32'h1, 1'b0);
        PcPlus4 = 32'h200; Offset = 32'h1;
        tick();
        check("ill.ill", 32'(IllegalOp), 32'd1);
        check("ill.ov",  32'(OutValid),  32'd0);
        check("ill.tgt", Target,         32'h204);
        check_counts("ill");
        branch(3'd1, 32'h9, 32'h9, 1'b1);
        CompareFlag = 1'b0;
        tick();
        check("nocmp.ov",   32'(OutValid),   32'd0);
        check("nocmp.res",  32'(Result),     32'd0);
        check("nocmp.ill",  32'(IllegalOp),  32'd0);
        check("nocmp.misp", 32'(Mispredict), 32'd0);
        check_counts("nocmp");

        // Target wrap-around and negative offset
        branch(3'd1, 32'h0, 32'h0, 1'b1);
        PcPlus4 = 32'hFFFFFFFC; Offset = 32'h1;
        tick();
        exp_bc++; exp_tc++;
        check("wrap.tgt", Target, 32'h0);
        PcPlus4 = 32'h10; Offset = 32'hFFFFFFFF;
        tick();
        exp_bc++; exp_tc++;
        check("neg.tgt", Target, 32'hC);
        check_counts("tgt");

        // Saturation from a clean start
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_bc = 0; exp_tc = 0;
        check_counts("rst2");
        for (int i = 0; i < 20; i++) begin
            branch(3'd1, 32'(i), 32'(i), 1'b1);
            tick();
            if (exp_bc < 15) exp_bc++;
            if (exp_tc < 15) exp_tc++;
            check_counts($sformatf("sat%0d", i));
        end

        // Reset while issuing and while stalled
        Stall = 1'b1; Reset = 1'b1;
        tick();
        exp_bc = 0; exp_tc = 0;
        check("rst3.ov",  32'(OutValid), 32'd0);
        check("rst3.tgt", Target,        32'd0);
        check_counts("rst3");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
